// File: rtl/dvp_pkg.sv
// Shared types and geometry constants for the DVP capture path and the DMA address generator.
package dvp_pkg;

   localparam int CNT_W        = 12;
   localparam int PIX_W        = 16;
   localparam int H_ACTIVE_DEF = 1280;
   localparam int V_ACTIVE_DEF = 720;

   typedef enum logic [1:0] {
      SKIP,
      WAIT,
      ACTIVE
   } state_t;

   // Geometry counters stick at all-ones instead of wrapping back to a plausible value.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/dvp_if.sv
// Frame-buffer video-in bus: frame sync plus a one-cycle pixel strobe with its RGB565 word.
interface dvp_if;
   import dvp_pkg::*;

   logic             vsync;
   logic             de;
   logic [PIX_W-1:0] data;

   modport master (output vsync, de, data);
   modport slave  (input  vsync, de, data);

endinterface

// File: rtl/dvp_byte_pack.sv
// Pairs consecutive sensor bytes into RGB565 words; first byte of a pair is the high byte.
module dvp_byte_pack
   import dvp_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             href,
   input  logic             en,
   input  logic [7:0]       db,
   output logic [PIX_W-1:0] data,
   output logic             de,
   output logic             pair,
   output logic             odd
);

   logic       phase_reg;
   logic [7:0] hi_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_reg <= 1'b0;
         hi_reg    <= 8'd0;
         data      <= '0;
         de        <= 1'b0;
      end else begin
         de <= 1'b0;
         if (!href) begin
            phase_reg <= 1'b0;
         end else begin
            phase_reg <= ~phase_reg;
            if (!phase_reg) begin
               hi_reg <= db;
            end else if (en) begin
               data <= {hi_reg, db};
               de   <= 1'b1;
            end
         end
      end
   end

   // pair marks the second byte this cycle; odd is the phase seen at a line end.
   assign pair = href & phase_reg;
   assign odd  = phase_reg;

endmodule

// File: rtl/dvp_capture.sv
// DVP sensor capture: frame-skip FSM, RGB565 pairing and sticky line/frame geometry checks.
module dvp_capture
   import dvp_pkg::*;
#(
   parameter int FRAME_SKIP = 10,
   parameter int H_ACTIVE   = H_ACTIVE_DEF,
   parameter int V_ACTIVE   = V_ACTIVE_DEF,
   parameter bit VSYNC_POL  = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmos_vsync,
   input  logic       cmos_href,
   input  logic [7:0] cmos_db,
   dvp_if.master      fb_vin,
   output logic [7:0] frame_cnt,
   output logic       line_err,
   output logic       frame_err
);

   localparam logic [CNT_W-1:0] SKIP_N = CNT_W'(FRAME_SKIP);
   localparam logic [CNT_W-1:0] H_N    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_N    = CNT_W'(V_ACTIVE);

   state_t           state_reg;
   logic             vs_reg, href_reg;
   logic [7:0]       db_reg;
   logic             vs_prev_reg, href_prev_reg, fb_vsync_reg;
   logic [CNT_W-1:0] skip_cnt_reg, line_cnt_reg, pix_cnt_reg;
   logic [CNT_W-1:0] line_cnt_next;
   logic             href_eff, vs_rise, vs_fall, href_fall, line_end, active;
   logic             pair, odd, pix_de;
   logic [PIX_W-1:0] pix_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vs_reg        <= 1'b0;
         href_reg      <= 1'b0;
         db_reg        <= 8'd0;
         vs_prev_reg   <= 1'b0;
         href_prev_reg <= 1'b0;
         fb_vsync_reg  <= 1'b0;
      end else begin
         vs_reg        <= VSYNC_POL ? cmos_vsync : ~cmos_vsync;
         href_reg      <= cmos_href;
         db_reg        <= cmos_db;
         vs_prev_reg   <= vs_reg;
         href_prev_reg <= href_eff;
         fb_vsync_reg  <= active & vs_reg;
      end
   end

   // Masking href with vs also closes a line that is still open when vs rises.
   assign href_eff  = href_reg & ~vs_reg;
   assign vs_rise   = vs_reg & ~vs_prev_reg;
   assign vs_fall   = ~vs_reg & vs_prev_reg;
   assign href_fall = href_prev_reg & ~href_eff;
   assign active    = (state_reg == ACTIVE);
   assign line_end  = active & href_fall;

   // A line ending in the vs-rise cycle is counted before the frame is judged.
   assign line_cnt_next = line_end ? sat_inc(line_cnt_reg) : line_cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= SKIP;
         skip_cnt_reg <= '0;
         line_cnt_reg <= '0;
         pix_cnt_reg  <= '0;
         frame_cnt    <= 8'd0;
         line_err     <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         if (href_fall) begin
            pix_cnt_reg <= '0;
         end else if (active && pair) begin
            pix_cnt_reg <= sat_inc(pix_cnt_reg);
         end

         case (state_reg)
            SKIP: begin
               if (FRAME_SKIP == 0) begin
                  state_reg <= WAIT;
               end else if (vs_rise) begin
                  skip_cnt_reg <= skip_cnt_reg + CNT_W'(1);
                  if (skip_cnt_reg + CNT_W'(1) == SKIP_N) state_reg <= WAIT;
               end
            end
            WAIT: begin
               if (vs_fall) begin
                  state_reg <= ACTIVE;
                  line_err  <= 1'b0;
                  frame_err <= 1'b0;
               end
            end
            ACTIVE: begin
               if (line_end && (pix_cnt_reg != H_N || odd)) line_err <= 1'b1;
               if (vs_fall) line_err <= 1'b0;
               if (vs_rise) begin
                  frame_err    <= (line_cnt_next != V_N);
                  frame_cnt    <= frame_cnt + 8'd1;
                  line_cnt_reg <= '0;
               end else begin
                  line_cnt_reg <= line_cnt_next;
               end
            end
            default: state_reg <= SKIP;
         endcase
      end
   end

   dvp_byte_pack u_pack (
      .clk  (clk),
      .rst  (rst),
      .href (href_eff),
      .en   (active),
      .db   (db_reg),
      .data (pix_data),
      .de   (pix_de),
      .pair (pair),
      .odd  (odd)
   );

   assign fb_vin.vsync = fb_vsync_reg;
   assign fb_vin.de    = pix_de;
   assign fb_vin.data  = pix_data;

endmodule
